// File: rtl/idv_osc_pkg.sv
// Shared constants, state encoding and populated-oscillator map for the IDV sweep sequencer.
// Build option IDV_DEBUG_CLK_SWEEP_EN adds the debug clock passthrough (index 63) to POPULATED_MASK.
package idv_osc_pkg;

    localparam int unsigned NUM_OSC     = 63;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned DWELL_W     = 16;
    localparam int unsigned WAKE_CYCLES = 4;
    localparam int unsigned GAP_CYCLES  = 2;

    typedef logic [NUM_OSC-1:0] osc_vec_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WAKE    = 3'd1;
    localparam state_t ST_SEARCH  = 3'd2;
    localparam state_t ST_SETTLE  = 3'd3;
    localparam state_t ST_MEASURE = 3'd4;
    localparam state_t ST_GAP     = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    // Bit i-1 represents oscillator i: physical sites 1-22, 32-40 and 48-51.
    localparam osc_vec_t POP_BASE = osc_vec_t'(22'h3F_FFFF)
                                  | (osc_vec_t'(9'h1FF) << 31)
                                  | (osc_vec_t'(4'hF) << 47);

`ifdef IDV_DEBUG_CLK_SWEEP_EN
    localparam osc_vec_t POPULATED_MASK = POP_BASE | (osc_vec_t'(1) << (NUM_OSC - 1));
`else
    localparam osc_vec_t POPULATED_MASK = POP_BASE;
`endif

    function automatic osc_vec_t idx_onehot(input logic [IDX_W-1:0] idx);
        return (idx == '0) ? '0 : (osc_vec_t'(1) << (idx - IDX_W'(1)));
    endfunction

endpackage

// File: rtl/idv_dwell_cnt.sv
// Loadable saturating down-counter; tc_o is high during the last cycle of a loaded window.
module idv_dwell_cnt
    import idv_osc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               tc_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // Flag is registered from the next count so it lines up with the window's final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d <= DWELL_W'(1));
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/idv_osc_sweep_seq.sv
// Sweeps the IDV left oscillator bank one oscillator at a time (settle, then gated measure).
// IDV_DEBUG_CLK_SWEEP_EN (via idv_osc_pkg) also sweeps the debug clock at index 63.
module idv_osc_sweep_seq
    import idv_osc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_OSC-1:0] osc_mask,
    input  logic [DWELL_W-1:0] settle_cycles,
    input  logic [DWELL_W-1:0] meas_cycles,
    output logic [NUM_OSC-1:0] enosc,
    output logic               sleep_b,
    output logic               meas_gate,
    output logic               meas_start,
    output logic               meas_end,
    output logic [IDX_W-1:0]   cur_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    state_t             state_q, state_d;
    osc_vec_t           eff_mask_q, eff_mask_d;
    logic [DWELL_W-1:0] settle_q, settle_d;
    logic [DWELL_W-1:0] meas_q, meas_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cand_q, cand_d;
    logic               aborted_q, aborted_d;

    osc_vec_t           enosc_q, enosc_d;
    logic               sleep_b_q, sleep_b_d;
    logic               gate_q, gate_d;
    logic               mstart_q, mstart_d;
    logic               mend_q, mend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_val;
    logic               cnt_tc;
    logic               active_q;

    idv_dwell_cnt u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_o       (cnt_tc)
    );

    assign active_q = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        eff_mask_d = eff_mask_q;
        settle_d   = settle_q;
        meas_d     = meas_q;
        idx_d      = idx_q;
        cand_d     = cand_q;
        aborted_d  = aborted_q;
        cnt_load   = 1'b0;
        cnt_val    = DWELL_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    eff_mask_d = osc_mask & POPULATED_MASK;
                    settle_d   = (settle_cycles == '0) ? DWELL_W'(1) : settle_cycles;
                    meas_d     = (meas_cycles == '0) ? DWELL_W'(1) : meas_cycles;
                    idx_d      = '0;
                    aborted_d  = 1'b0;
                    state_d    = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (cnt_tc) begin
                    cand_d  = IDX_W'(1);
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Candidate 0 marks that the last visited index was NUM_OSC.
                if (cand_q == '0) begin
                    state_d = ST_DONE;
                end else if (eff_mask_q[cand_q - IDX_W'(1)]) begin
                    idx_d   = cand_q;
                    state_d = ST_SETTLE;
                end else if (cand_q == IDX_W'(NUM_OSC)) begin
                    state_d = ST_DONE;
                end else begin
                    cand_d = cand_q + IDX_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (cnt_tc) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_tc) begin
                    cand_d  = (idx_q == IDX_W'(NUM_OSC)) ? '0 : idx_q + IDX_W'(1);
                    state_d = ST_SEARCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && active_q) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
        end
        if (state_d == ST_DONE) idx_d = '0;

        if (state_d != state_q) begin
            case (state_d)
                ST_WAKE:    begin cnt_load = 1'b1; cnt_val = DWELL_W'(WAKE_CYCLES); end
                ST_SETTLE:  begin cnt_load = 1'b1; cnt_val = settle_d; end
                ST_MEASURE: begin cnt_load = 1'b1; cnt_val = meas_d; end
                ST_GAP:     begin cnt_load = 1'b1; cnt_val = DWELL_W'(GAP_CYCLES); end
                default:    cnt_load = 1'b0;
            endcase
        end

        // Outputs derive from the next state so every output is a plain register.
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        sleep_b_d = busy_d;
        enosc_d   = ((state_d == ST_SETTLE) || (state_d == ST_MEASURE)) ? idx_onehot(idx_d) : '0;
        gate_d    = (state_d == ST_MEASURE);
        mstart_d  = (state_d == ST_MEASURE) && (state_q != ST_MEASURE);
        mend_d    = (state_q == ST_MEASURE) && (state_d != ST_MEASURE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            eff_mask_q <= '0;
            settle_q   <= '0;
            meas_q     <= '0;
            idx_q      <= '0;
            cand_q     <= '0;
            aborted_q  <= 1'b0;
            enosc_q    <= '0;
            sleep_b_q  <= 1'b0;
            gate_q     <= 1'b0;
            mstart_q   <= 1'b0;
            mend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            eff_mask_q <= eff_mask_d;
            settle_q   <= settle_d;
            meas_q     <= meas_d;
            idx_q      <= idx_d;
            cand_q     <= cand_d;
            aborted_q  <= aborted_d;
            enosc_q    <= enosc_d;
            sleep_b_q  <= sleep_b_d;
            gate_q     <= gate_d;
            mstart_q   <= mstart_d;
            mend_q     <= mend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign enosc      = enosc_q;
    assign sleep_b    = sleep_b_q;
    assign meas_gate  = gate_q;
    assign meas_start = mstart_q;
    assign meas_end   = mend_q;
    assign cur_idx    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_idv_osc_sweep_seq.sv
// Bench for idv_osc_sweep_seq: directed and random sweeps compared cycle by cycle
// against a trace built from the sweep rules (phase lengths per visited oscillator).
module tb_idv_osc_sweep_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [62:0] osc_mask;
    logic [15:0] settle_cycles;
    logic [15:0] meas_cycles;
    logic [62:0] enosc;
    logic        sleep_b;
    logic        meas_gate;
    logic        meas_start;
    logic        meas_end;
    logic [5:0]  cur_idx;
    logic        busy;
    logic        done;
    logic        aborted;

    idv_osc_sweep_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .osc_mask      (osc_mask),
        .settle_cycles (settle_cycles),
        .meas_cycles   (meas_cycles),
        .enosc         (enosc),
        .sleep_b       (sleep_b),
        .meas_gate     (meas_gate),
        .meas_start    (meas_start),
        .meas_end      (meas_end),
        .cur_idx       (cur_idx),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [62:0] en;
        logic [5:0]  idx;
        logic        sleep;
        logic        gate;
        logic        mst;
        logic        mend;
        logic        busy;
        logic        done;
        logic        abt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   abt_model = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit populated(input int i);
`ifdef IDV_DEBUG_CLK_SWEEP_EN
        if (i == 63) return 1'b1;
`endif
        return (i >= 1 && i <= 22) || (i >= 32 && i <= 40) || (i >= 48 && i <= 51);
    endfunction

    function automatic exp_t mk(input logic [62:0] en, input int idx, input bit sl, input bit g,
                                input bit ms, input bit me, input bit b, input bit d, input bit a);
        exp_t e;
        e.en = en; e.idx = 6'(idx); e.sleep = sl; e.gate = g; e.mst = ms;
        e.mend = me; e.busy = b; e.done = d; e.abt = a;
        return e;
    endfunction

    function automatic logic [62:0] bit_of(input int c);
        logic [62:0] v;
        v = '0;
        v[c-1] = 1'b1;
        return v;
    endfunction

    task automatic compare_cycle(input string tag, input exp_t e);
        logic [12:0] got_f, exp_f;
        got_f = {cur_idx, sleep_b, meas_gate, meas_start, meas_end, busy, done, aborted};
        exp_f = {e.idx, e.sleep, e.gate, e.mst, e.mend, e.busy, e.done, e.abt};
        check_eq({tag, ".enosc"}, 64'(enosc), 64'(e.en));
        check_eq({tag, ".flags"}, 64'(got_f), 64'(exp_f));
        check_eq({tag, ".onehot"}, 64'($countones(enosc) <= 1), 64'(1));
    endtask

    // abort_at: -1 none, >=0 fixed trace cycle, -2 random active cycle.
    task automatic run_sweep(input string tag, input logic [62:0] mask, input int s, input int m,
                             input int abort_at_in, input bit spur, input bit abort_with_start);
        int s_eff, m_eff, last, abort_at, spur_at, done_idx;
        bit me;
        s_eff = (s == 0) ? 1 : s;
        m_eff = (m == 0) ? 1 : m;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk('0, 0, 1, 0, 0, 0, 1, 0, 0));
        last = 0;
        for (int c = 1; c <= 63; c++) begin
            exp_q.push_back(mk('0, last, 1, 0, 0, 0, 1, 0, 0));
            if (mask[c-1] && populated(c)) begin
                for (int j = 0; j < s_eff; j++) exp_q.push_back(mk(bit_of(c), c, 1, 0, 0, 0, 1, 0, 0));
                for (int j = 0; j < m_eff; j++) exp_q.push_back(mk(bit_of(c), c, 1, 1, j == 0, 0, 1, 0, 0));
                for (int j = 0; j < 2; j++) exp_q.push_back(mk('0, c, 1, 0, 0, j == 0, 1, 0, 0));
                last = c;
                if (c == 63) exp_q.push_back(mk('0, last, 1, 0, 0, 0, 1, 0, 0));
            end
        end
        abort_at = abort_at_in;
        if (abort_at == -2) abort_at = int'($urandom_range(0, exp_q.size() - 1));
        if (abort_at >= 0 && abort_at < exp_q.size()) begin
            me = exp_q[abort_at].gate;
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(mk('0, 0, 0, 0, 0, me, 0, 1, 1));
            abt_model = 1'b1;
        end else begin
            abort_at = -1;
            exp_q.push_back(mk('0, 0, 0, 0, 0, 0, 0, 1, 0));
            abt_model = 1'b0;
        end
        done_idx = exp_q.size() - 1;
        for (int i = 0; i < 2; i++) exp_q.push_back(mk('0, 0, 0, 0, 0, 0, 0, 0, abt_model));
        spur_at = (spur && done_idx > 0) ? int'($urandom_range(0, done_idx - 1)) : -1;

        @(negedge clk);
        osc_mask      = mask;
        settle_cycles = 16'(s);
        meas_cycles   = 16'(m);
        start         = 1'b1;
        abort         = abort_with_start;
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            compare_cycle($sformatf("%s[%0d]", tag, t), exp_q[t]);
            if (t == abort_at) abort = 1'b1;
            if (t == spur_at) start = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".enosc"}, 64'(enosc), 64'(0));
        check_eq({tag, ".flags"}, 64'({cur_idx, sleep_b, meas_gate, meas_start, meas_end,
                                       busy, done, aborted}), 64'(0));
    endtask

    initial begin
        logic [62:0] rmask;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        osc_mask = '0; settle_cycles = '0; meas_cycles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        run_sweep("osc1", 63'(1), 3, 10, -1, 1'b0, 1'b0);
        run_sweep("all_ones", '1, 1, 1, -1, 1'b0, 1'b0);
        run_sweep("unpop_23_31", 63'(9'h1FF) << 22, 2, 2, -1, 1'b0, 1'b0);
        // 5th MEASURE cycle of osc 2 with settle=2, meas=8: 4 + 1 + 12 + 1 + 2 + 4.
        run_sweep("abort_osc2", 63'(3), 2, 8, 24, 1'b0, 1'b0);

        // Abort while idle leaves the sticky flag alone and does not pulse done.
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_cycle($sformatf("idle_abort[%0d]", i), mk('0, 0, 0, 0, 0, 0, 0, 0, abt_model));
        end
        abort = 1'b0;

        run_sweep("osc63_abort_with_start", 63'(1) << 62, 2, 3, -1, 1'b0, 1'b1);
        run_sweep("zero_dwell", 63'(1) | (63'(1) << 50), 0, 0, -1, 1'b1, 1'b0);

        // Reset in the middle of settling osc 1 clears every output at once.
        @(negedge clk);
        osc_mask = 63'(1); settle_cycles = 16'd10; meas_cycles = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst.enosc", 64'(enosc), 64'(1));
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_settle");
        @(negedge clk);
        rst = 1'b0;
        abt_model = 1'b0;
        run_sweep("after_rst", 63'(1) | (63'(1) << 4), 2, 2, -1, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            rmask = 63'({$urandom(), $urandom()});
            if (k % 3 == 0) rmask = rmask & 63'({$urandom(), $urandom()});
            run_sweep($sformatf("rnd%0d", k), rmask, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1) ? -2 : -1,
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idv_osc_sweep_seq.md
Name: idv_osc_sweep_seq

Overview:
- Single-clock sequencer directly upstream of the IDV left oscillator bank.
- Drives the bank's one-hot enosc[63:1] and sleep_b. Steps through a programmed subset of oscillators, one at a time, each with a settle window then a measure window.
- Gives the downstream frequency counter a gate and start/end strobes per oscillator.
- Guarantees at most one oscillator is ever enabled, so the bank's wired-AND output carries exactly one source.

Parameters:
- NUM_OSC, 63, highest oscillator index (indices 1..NUM_OSC).
- IDX_W, 6, width of the index bus (must hold NUM_OSC).
- DWELL_W, 16, width of the settle and measure cycle counters.
- WAKE_CYCLES, 4, cycles between sleep_b rising and the first enable.
- GAP_CYCLES, 2, idle cycles with all enosc low between oscillators.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse that begins a sweep; ignored while busy.
- abort  in  1  level; terminates an active sweep.
- osc_mask  in  NUM_OSC  bit i-1 set = include oscillator i; sampled at start.
- settle_cycles  in  DWELL_W  settle length per oscillator; 0 treated as 1.
- meas_cycles  in  DWELL_W  measure length per oscillator; 0 treated as 1.
- enosc  out  NUM_OSC  one-hot or zero oscillator enable (bit i-1 = oscillator i).
- sleep_b  out  1  bank wake; high from WAKE through GAP.
- meas_gate  out  1  high for exactly meas_cycles cycles per oscillator.
- meas_start  out  1  pulse on the first gate cycle.
- meas_end  out  1  pulse on the cycle after the last gate cycle.
- cur_idx  out  IDX_W  index currently enabled; 0 when none.
- busy  out  1  high from the cycle after start until done.
- done  out  1  single-cycle pulse at sweep end (normal or aborted).
- aborted  out  1  sticky; set on abort, cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0. FSM is IDLE and sleep_b is 0.
- States and transitions:
  - IDLE: on start, latch eff_mask = osc_mask & POPULATED_MASK, settle length, meas length; cur_idx=0 -> WAKE.
  - WAKE: sleep_b=1, count WAKE_CYCLES -> SEARCH.
  - SEARCH: examine one candidate index per cycle, ascending from cur_idx+1. Index with eff_mask bit set -> SETTLE (enosc bit registered on entry). Candidate passes NUM_OSC -> DONE.
  - SETTLE: count settle cycles -> MEASURE.
  - MEASURE: meas_gate=1, count meas cycles -> GAP; meas_end pulses on the first GAP cycle.
  - GAP: enosc=0 and cur_idx held, count GAP_CYCLES -> SEARCH.
  - DONE: sleep_b=0, enosc=0, done=1 for one cycle -> IDLE.
- Empty effective mask: WAKE, then NUM_OSC SEARCH cycles, then DONE. No gate is issued and done still pulses.
- abort in any non-IDLE state:
  - next cycle enosc=0 and meas_gate=0;
  - if abort lands mid-MEASURE, meas_end still pulses so the counter closes;
  - aborted=1, then DONE.
  - abort in IDLE is ignored.
- start while busy is ignored. start coincident with abort in IDLE: start wins.
- All outputs are registered. enosc never has more than one bit high, including on transitions.
- Counters saturate at terminal value and do not wrap. Index arithmetic is IDX_W wide and compares against NUM_OSC before increment overflow.

Optional Feature:
- IDV_DEBUG_CLK_SWEEP_EN:
  - Defined: index 63 (debug clock passthrough) is included in POPULATED_MASK and swept like any oscillator.
  - Undefined: bit 63 is forced 0 in eff_mask, so enosc[63] is never asserted.

Decomposition:
- Package idv_osc_pkg holds:
  - POPULATED_MASK constant, bits 1-22, 32-40, 48-51 (plus 63 under the macro);
  - the state enum typedef;
  - IDX_W and DWELL_W defaults.
- Sub-module idv_dwell_cnt: loadable saturating down-counter with a terminal-count flag, shared by the wake, settle, measure and gap windows.

Test Plan:
- osc_mask bit0 only (osc1), settle=3, meas=10: start -> enosc[0] high 13 cycles; meas_gate high 10 cycles starting 3 cycles after enable; meas_end 1 cycle after gate; done follows; cur_idx=1 during dwell.
- osc_mask all ones, settle=1, meas=1: sweep visits exactly 1-22, 32-40, 48-51 in order; never 23-31, 41-47, 52-63 (macro off); one-hot checked every cycle.
- osc_mask only bits for 23-31: WAKE, SEARCH to end, done pulse, meas_start never asserts, enosc stays 0.
- abort raised on the 5th MEASURE cycle of osc 2: enosc=0 next cycle, meas_end pulses, aborted=1, done pulses, sleep_b=0 after.
- Macro on, osc_mask bit 62 only: enosc[62] asserted for settle+meas cycles. Macro off: never asserted.
- rst asserted mid-SETTLE: all outputs 0 immediately. After release, start runs a fresh sweep from index 1.
